// File: rtl/param_alu_datapath.sv
// Parametrised register-file datapath with a built-in micro-sequencer: one start
// pulse runs a full register-to-register ALU op, or a shift-add multiply into HI/LO.
module param_alu_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic [2:0] {IDLE, S_Y, S_Z, S_MUL, S_WB, S_DONE} state_t;

  state_t            state, next_state;
  logic [WIDTH-1:0]  regs [NREGS];
  logic [WIDTH-1:0]  y, zhigh, zlow, hi, lo, mcand, mplier;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [AW-1:0]     ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]  b_val, alu_res;
  logic [WIDTH:0]    mul_sum;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = S_Y;
      S_Y:     next_state = S_Z;
      S_Z:     next_state = (op_q == OP_MUL) ? S_MUL : S_WB;
      S_MUL:   if (count == CW'(WIDTH - 1)) next_state = S_WB;
      S_WB:    next_state = S_DONE;
      S_DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    b_val   = regs[rb_q];
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = y + b_val;
      OP_SUB:  alu_res = y - b_val;
      OP_AND:  alu_res = y & b_val;
      OP_OR:   alu_res = y | b_val;
      OP_SHL:  alu_res = y << b_val[SW-1:0];
      OP_SHR:  alu_res = y >> b_val[SW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Right-shifting accumulator: the adder carry becomes the new MSB of Zhigh.
  assign mul_sum = {1'b0, zhigh} + (mplier[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      y      <= '0;
      zhigh  <= '0;
      zlow   <= '0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) regs[wr_addr] <= wr_data;
          if (start) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
          end
        end
        S_Y: y <= regs[ra_q];
        S_Z: begin
          if (op_q == OP_MUL) begin
            mcand  <= y;
            mplier <= b_val;
            zhigh  <= '0;
            zlow   <= '0;
            count  <= '0;
          end else if (op_q != OP_RSV) begin
            zhigh <= '0;
            zlow  <= alu_res;
          end
        end
        S_MUL: begin
          zhigh  <= mul_sum[WIDTH:1];
          zlow   <= {mul_sum[0], zlow[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        S_WB: begin
          if (op_q == OP_MUL) begin
            hi <= zhigh;
            lo <= zlow;
          end else if (op_q != OP_RSV) begin
            regs[rc_q] <= zlow;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = regs[rd_addr];
  assign hi_out  = hi;
  assign lo_out  = lo;
  assign busy    = (state != IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);
  assign err     = (state == S_DONE) && (op_q == OP_RSV);

endmodule

// File: tb/tb_param_alu_datapath.sv
// Bench for param_alu_datapath: a transaction-level model predicts every output each
// cycle; directed vectors add literal expectations, plus a WIDTH=16/NREGS=8 multiply.
module tb_param_alu_datapath;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear = 1'b1, start = 1'b0, wr_en = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0, wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data, hi_out, lo_out;
  logic        busy, done, err;

  logic        s_clear = 1'b1, s_start = 1'b0, s_wr_en = 1'b0;
  logic [2:0]  s_op = '0, s_ra = '0, s_rb = '0, s_rc = '0, s_wr_addr = '0, s_rd_addr = '0;
  logic [15:0] s_wr_data = '0;
  logic [15:0] s_rd_data, s_hi, s_lo;
  logic        s_busy, s_done, s_err;

  param_alu_datapath dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .err(err)
  );

  param_alu_datapath #(.WIDTH(16), .NREGS(8)) dut_small (
    .clock(clock), .clear(s_clear), .start(s_start), .op(s_op), .ra(s_ra), .rb(s_rb), .rc(s_rc),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .hi_out(s_hi), .lo_out(s_lo), .busy(s_busy), .done(s_done), .err(s_err)
  );

  int n_cmp = 0, n_err = 0, cyc = 0, done_count = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] expectedResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0:    return {32'b0, a + b};
      3'd1:    return {32'b0, a - b};
      3'd2:    return {32'b0, a & b};
      3'd3:    return {32'b0, a | b};
      3'd4:    return {32'b0, a << b[4:0]};
      3'd5:    return {32'b0, a >> b[4:0]};
      3'd6:    return {32'b0, a} * {32'b0, b};
      default: return 64'b0;
    endcase
  endfunction

  // Transaction model: an accepted op completes at a fixed cycle; its result appears then.
  logic [31:0] m_regs [16];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res;
  logic [2:0]  m_op;
  logic [3:0]  m_rc;
  bit          m_active = 0, m_valid = 0;
  int          m_done_cyc = 0;

  always @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_hi = '0;
      m_lo = '0;
      m_active = 0;
      m_valid = 1;
    end else if (!m_active) begin
      if (wr_en) m_regs[wr_addr] = wr_data;
      if (start) begin
        m_res      = expectedResult(op, m_regs[ra], m_regs[rb]);
        m_op       = op;
        m_rc       = rc;
        m_active   = 1;
        m_done_cyc = cyc + ((op == 3'd6) ? 36 : 4);
      end
    end else if (cyc == m_done_cyc) begin
      m_active = 0;
    end
    cyc++;
    if (m_active && cyc == m_done_cyc) begin
      if (m_op == 3'd6) {m_hi, m_lo} = m_res;
      else if (m_op != 3'd7) m_regs[m_rc] = m_res[31:0];
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      checkOutput("busy", busy, m_active && cyc < m_done_cyc);
      checkOutput("done", done, m_active && cyc == m_done_cyc);
      checkOutput("err", err, m_active && cyc == m_done_cyc && m_op == 3'd7);
      checkOutput("hi_out", hi_out, m_hi);
      checkOutput("lo_out", lo_out, m_lo);
      checkOutput("rd_data", rd_data, m_regs[rd_addr]);
    end
    if (done === 1'b1) done_count++;
  end

  task automatic applyStimulus(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                               input logic s, input logic [2:0] o, input logic [3:0] a,
                               input logic [3:0] b, input logic [3:0] c);
    @(posedge clock);
    #1;
    wr_en = w; wr_addr = wa; wr_data = wd;
    start = s; op = o; ra = a; rb = b; rc = c;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0);
    idle();
  endtask

  // Returns the number of cycles from the accept cycle to the done pulse, -1 on timeout.
  task automatic runOp(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, output int lat);
    applyStimulus(w, wa, wd, 1'b1, o, a, b, c);
    idle();
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic peek(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_addr = a;
    #1;
    checkOutput(name, rd_data, exp);
    checkOutput({name, " model"}, m_regs[a], exp);
  endtask

  int lat, d0;

  initial begin
    @(posedge clock); #1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset hi", hi_out, 0);
    peek(4'd0, 32'h0, "reset R0");

    writeReg(4'd1, 32'h5);
    writeReg(4'd2, 32'h3);
    runOp(1'b0, 4'd0, 32'd0, 3'd0, 4'd1, 4'd2, 4'd3, lat);
    checkOutput("ADD latency", lat, 4);
    checkOutput("ADD err", err, 0);
    peek(4'd3, 32'h8, "ADD R3");

    runOp(1'b1, 4'd1, 32'd9, 3'd0, 4'd1, 4'd1, 4'd7, lat);
    peek(4'd7, 32'd18, "write-then-start R7");

    writeReg(4'd1, 32'h3);
    writeReg(4'd2, 32'h5);
    runOp(1'b0, 4'd0, 32'd0, 3'd1, 4'd1, 4'd2, 4'd4, lat);
    peek(4'd4, 32'hFFFF_FFFE, "SUB R4");
    writeReg(4'd2, 32'h21);
    runOp(1'b0, 4'd0, 32'd0, 3'd4, 4'd1, 4'd2, 4'd5, lat);
    peek(4'd5, 32'h6, "SHL R5");

    writeReg(4'd1, 32'hF0F0_00FF);
    writeReg(4'd2, 32'h0FF0_0F0F);
    runOp(1'b0, 4'd0, 32'd0, 3'd2, 4'd1, 4'd2, 4'd8, lat);
    peek(4'd8, 32'h00F0_000F, "AND R8");
    runOp(1'b0, 4'd0, 32'd0, 3'd3, 4'd1, 4'd2, 4'd9, lat);
    peek(4'd9, 32'hFFF0_0FFF, "OR R9");
    writeReg(4'd2, 32'h24);
    runOp(1'b0, 4'd0, 32'd0, 3'd5, 4'd1, 4'd2, 4'd10, lat);
    peek(4'd10, 32'h0F0F_000F, "SHR R10");

    writeReg(4'd1, 32'hFFFF_FFFF);
    writeReg(4'd2, 32'h2);
    runOp(1'b0, 4'd0, 32'd0, 3'd6, 4'd1, 4'd2, 4'd11, lat);
    checkOutput("MUL latency", lat, 36);
    checkOutput("MUL hi", hi_out, 32'h1);
    checkOutput("MUL lo", lo_out, 32'hFFFF_FFFE);
    peek(4'd11, 32'h0, "MUL R11 untouched");

    // Host write and second start issued mid-multiply must both be dropped.
    d0 = done_count;
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 3'd6, 4'd2, 4'd2, 4'd0);
    idle();
    repeat (4) idle();
    applyStimulus(1'b1, 4'd1, 32'hDEAD_BEEF, 1'b1, 3'd0, 4'd1, 4'd2, 4'd12);
    idle();
    repeat (60) @(posedge clock);
    @(negedge clock);
    checkOutput("busy MUL done pulses", done_count - d0, 1);
    checkOutput("busy MUL lo", lo_out, 32'h4);
    peek(4'd1, 32'hFFFF_FFFF, "busy write dropped R1");
    peek(4'd12, 32'h0, "second start dropped R12");

    runOp(1'b0, 4'd0, 32'd0, 3'd7, 4'd1, 4'd2, 4'd6, lat);
    checkOutput("op7 latency", lat, 4);
    checkOutput("op7 err", err, 1);
    peek(4'd6, 32'h0, "op7 R6 untouched");
    writeReg(4'd1, 32'h7);
    runOp(1'b0, 4'd0, 32'd0, 3'd0, 4'd1, 4'd1, 4'd1, lat);
    peek(4'd1, 32'd14, "alias ADD R1");

    // Clear lands at N+20 of a multiply.
    d0 = done_count;
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 3'd6, 4'd1, 4'd1, 4'd0);
    idle();
    repeat (19) @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    checkOutput("post-clear busy", busy, 0);
    repeat (50) @(posedge clock);
    @(negedge clock);
    checkOutput("aborted MUL done pulses", done_count - d0, 0);
    checkOutput("post-clear hi", hi_out, 0);
    checkOutput("post-clear lo", lo_out, 0);
    for (int i = 0; i < 16; i++) peek(4'(i), 32'h0, "post-clear reg");

    @(posedge clock); #1 s_clear = 1'b0;
    s_wr_en = 1'b1; s_wr_addr = 3'd1; s_wr_data = 16'hFFFF;
    @(posedge clock); #1 s_wr_addr = 3'd2;
    @(posedge clock); #1 s_wr_en = 1'b0; s_start = 1'b1; s_op = 3'd6; s_ra = 3'd1; s_rb = 3'd2;
    @(posedge clock); #1 s_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (s_done === 1'b1) begin
        lat = k;
        break;
      end
    end
    checkOutput("W16 MUL latency", lat, 20);
    checkOutput("W16 MUL hi", s_hi, 16'hFFFE);
    checkOutput("W16 MUL lo", s_lo, 16'h0001);
    checkOutput("W16 MUL err", s_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
